ahb_sram_slave: RTL
===================

// Module: ahb_sram_slave
// PURPOSE
//  AHB slave: on-chip scratchpad SRAM. It sits beside mctrl on the same AHB slave bus and
//  answers the transfers that the bench's AHB transactor initiates.
//  Supports single and INCR/WRAP bursts, byte/half/word writes and programmable wait states.
//  Big-endian lanes: byte at addr[1:0]=0 is on hwdata/hrdata[31:24].
// PARAMETERS
//  HINDEX  0    bit of ahbsi_hsel that selects this slave
//  ABITS   10   word-address width; memory depth = 2**ABITS x 32 bit (4 KB default)
//  WAITS   0    wait states inserted per data phase, range 0..7
// PORTS
//  clk           in   1          system clock, rising edge
//  rst           in   1          asynchronous reset, active low
//  ahbsi_hsel    in   NAHBSLV    slave selects, [0:NAHBSLV-1]; this slave uses bit HINDEX
//  ahbsi_haddr   in   32         address
//  ahbsi_hwrite  in   1          1 = write
//  ahbsi_htrans  in   2          IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
//  ahbsi_hsize   in   3          0 = byte, 1 = half, 2 = word
//  ahbsi_hburst  in   3          burst type (informational only; each beat is decoded independently)
//  ahbsi_hwdata  in   32         write data, valid in the data phase
//  ahbsi_hready  in   1          bus-wide HREADY
//  ahbso_hready  out  1          slave ready
//  ahbso_hresp   out  2          OKAY=00, ERROR=01
//  ahbso_hrdata  out  32         read data
//  ahbso_hcache  out  1          constant 1 (cacheable)
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, ahbso_hready=1, hresp=00, hrdata=0. Memory contents are not cleared.
//  Accept rule: an address phase is accepted on a clk edge where hsel[HINDEX]=1,
//    ahbsi_hready=1 and htrans[1]=1. On accept, register addr[ABITS+1:0], hwrite and hsize.
//  IDLE/BUSY transfers, or hsel=0: no access; slave keeps hready=1, hresp=OKAY.
//  FSM: IDLE -> DATA on accept; DATA -> WAIT when WAITS>0.
//    WAIT: counter loaded with WAITS, decrements each clk; hready=0 while counter!=0.
//    Data phase completes on the cycle hready=1. Back-to-back accepts are allowed in that
//    cycle (pipelined), so WAITS=0 gives one beat per clk.
//  Read: the SRAM is addressed from the address phase and hrdata is valid in the last data-phase
//    cycle. Zero-wait read latency is 1 clk after the address phase. hsize<2 still returns the full word.
//  Write: hwdata is captured and written at the edge that ends the data phase.
//    Byte enables: size 0 -> lane addr[1:0]; size 1 -> lanes by addr[1]; size 2 -> all lanes.
//  Read-after-write hazard: a read accepted at the same edge as a pending write to the same word
//    returns merged data (new lanes from hwdata, others from SRAM). No extra wait state.
//  haddr[1:0] misalignment for the given hsize is ignored; addresses are truncated to the size boundary.
//  Addresses beyond the depth: see CONFIGURATION.
//  Reset during a wait or error sequence: abort at once. No write is performed for the aborted beat.
// CONFIGURATION
//  AHBRAM_ERR_EN defined:
//    - haddr[19:ABITS+2]!=0, or hsize>2, gives a two-cycle ERROR response:
//      ERR1: hready=0, hresp=01; ERR2: hready=1, hresp=01. No memory access.
//    - An address phase presented during ERR2 is accepted normally.
//    - Wait states are not inserted before ERR1.
//  AHBRAM_ERR_EN not defined:
//    - Addresses wrap modulo 2**(ABITS+2).
//    - hsize>2 is treated as a word.
//    - hresp is always OKAY.
// TESTING
//  T1 single: write 0x20000000<=0x11223344, then read 0x20000000 -> 0x11223344, OKAY, no hready low (WAITS=0).
//  T2 byte lanes: word 0x0 <- 0xAABBCCDD; byte write 0x01 at 0x2 -> read 0x0 = 0xAABB01DD.
//  T3 INCR4 write 0x10..0x1C <= 1,2,3,4, back-to-back; INCR4 read -> 1,2,3,4 in 5 clk total (WAITS=0).
//  T4 WAITS=3: a single read holds hready low exactly 3 clk, then data is valid; write pipelined after it lands correctly.
//  T5 RAW: write 0x8 <= 0x5, immediately followed by read 0x8 in the next address phase -> 0x5.
//  T6 ERR_EN: read at 0x1000 with ABITS=10 -> ERR1 (hready=0, hresp=01), then ERR2 (hready=1, hresp=01).
//     Without ERR_EN the same read returns the word at 0x0 with OKAY.
//     Also assert rst low mid-wait -> hready=1 within 0 clk.

Source files
------------

// File: rtl/ahb_sram_slave_if.sv
// AHB slave-side bus bundle: master-driven ahbsi_* inputs and slave-driven ahbso_* responses.
// Latency: none; wires only.
// Backpressure: ahbso_hready from the slave; ahbsi_hready is the bus-wide ready.
interface ahb_sram_slave_if #(
    parameter int NAHBSLV = 16
);
    logic [0:NAHBSLV-1] ahbsi_hsel;
    logic [31:0]        ahbsi_haddr;
    logic               ahbsi_hwrite;
    logic [1:0]         ahbsi_htrans;
    logic [2:0]         ahbsi_hsize;
    logic [2:0]         ahbsi_hburst;
    logic [31:0]        ahbsi_hwdata;
    logic               ahbsi_hready;
    logic               ahbso_hready;
    logic [1:0]         ahbso_hresp;
    logic [31:0]        ahbso_hrdata;
    logic               ahbso_hcache;

    modport master (
        output ahbsi_hsel, ahbsi_haddr, ahbsi_hwrite, ahbsi_htrans, ahbsi_hsize,
               ahbsi_hburst, ahbsi_hwdata, ahbsi_hready,
        input  ahbso_hready, ahbso_hresp, ahbso_hrdata, ahbso_hcache
    );

    modport slave (
        input  ahbsi_hsel, ahbsi_haddr, ahbsi_hwrite, ahbsi_htrans, ahbsi_hsize,
               ahbsi_hburst, ahbsi_hwdata, ahbsi_hready,
        output ahbso_hready, ahbso_hresp, ahbso_hrdata, ahbso_hcache
    );
endinterface

// File: rtl/ahb_sram_slave.sv
// AHB scratchpad SRAM slave, big-endian lanes; AHBRAM_ERR_EN adds out-of-range/hsize ERROR responses.
// Latency: read data 1 clk after the address phase plus WAITS wait states; one beat/clk when WAITS=0.
// Backpressure: hready low for WAITS cycles per data phase (and during ERR1); reset aborts at once.
module ahb_sram_slave #(
    parameter int HINDEX = 0,
    parameter int ABITS  = 10,
    parameter int WAITS  = 0
) (
    input  logic          clk,
    input  logic          rst,
    ahb_sram_slave_if.slave ahb
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
        S_WAIT,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t           state, state_nxt;
    logic [2:0]       cnt, cnt_nxt;
    logic [ABITS+1:0] addr_q;
    logic             hwrite_q;
    logic [2:0]       hsize_q;
    logic [31:0]      hrdata_q;
    logic             hready;
    logic [1:0]       hresp;

    logic [31:0]      mem [0:(2**ABITS)-1];

    logic             accept;
    logic             addr_err;
    logic             wr_en;
    logic [ABITS-1:0] wr_word;
    logic [ABITS-1:0] rd_word;
    logic [3:0]       wr_be;
    logic [31:0]      wr_mask;
    logic [31:0]      rd_word_dat;
    logic [31:0]      rd_merge;
    logic             unused_bits;

    assign accept = ahb.ahbsi_hsel[HINDEX] & ahb.ahbsi_hready & ahb.ahbsi_htrans[1];

`ifdef AHBRAM_ERR_EN
    assign addr_err = ((ahb.ahbsi_haddr[19:0] >> (ABITS + 2)) != 20'd0) ||
                      (ahb.ahbsi_hsize > 3'd2);
`else
    assign addr_err = 1'b0;
`endif

    // Bit 3 of the enable vector is byte lane 0 (hwdata[31:24]).
    function automatic logic [3:0] lane_en(input logic [1:0] a, input logic [2:0] sz);
        logic [3:0] be;
        case (sz)
            3'd0:    be = 4'b1000 >> a;
            3'd1:    be = a[1] ? 4'b0011 : 4'b1100;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    assign wr_en       = (state == S_DATA) && hwrite_q;
    assign wr_word     = addr_q[ABITS+1:2];
    assign rd_word     = ahb.ahbsi_haddr[ABITS+1:2];
    assign wr_be       = lane_en(addr_q[1:0], hsize_q);
    assign wr_mask     = {{8{wr_be[3]}}, {8{wr_be[2]}}, {8{wr_be[1]}}, {8{wr_be[0]}}};
    assign rd_word_dat = mem[rd_word];

    // A read accepted on the edge that commits a write to the same word sees the new lanes.
    assign rd_merge = (wr_en && (wr_word == rd_word)) ?
                      ((rd_word_dat & ~wr_mask) | (ahb.ahbsi_hwdata & wr_mask)) : rd_word_dat;

    assign unused_bits = ^{ahb.ahbsi_haddr, ahb.ahbsi_hburst, ahb.ahbsi_hsel, ahb.ahbsi_htrans};

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) begin
                    mem[wr_word][i*8 +: 8] <= ahb.ahbsi_hwdata[i*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            cnt      <= 3'd0;
            addr_q   <= '0;
            hwrite_q <= 1'b0;
            hsize_q  <= 3'd0;
            hrdata_q <= 32'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept && !addr_err) begin
                addr_q   <= ahb.ahbsi_haddr[ABITS+1:0];
                hwrite_q <= ahb.ahbsi_hwrite;
                hsize_q  <= ahb.ahbsi_hsize;
                if (!ahb.ahbsi_hwrite) begin
                    hrdata_q <= rd_merge;
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        hready    = 1'b1;
        hresp     = 2'b00;
        case (state)
            S_WAIT: begin
                hready  = 1'b0;
                cnt_nxt = cnt - 3'd1;
                if (cnt == 3'd1) begin
                    state_nxt = S_DATA;
                end
            end
            S_ERR1: begin
                hready    = 1'b0;
                hresp     = 2'b01;
                state_nxt = S_ERR2;
            end
            default: begin
                // IDLE, DATA and ERR2 all end a data phase here, so a new address phase may enter.
                if (state == S_ERR2) begin
                    hresp = 2'b01;
                end
                if (accept) begin
                    if (addr_err) begin
                        state_nxt = S_ERR1;
                    end else if (WAITS > 0) begin
                        state_nxt = S_WAIT;
                        cnt_nxt   = 3'(WAITS);
                    end else begin
                        state_nxt = S_DATA;
                    end
                end else begin
                    state_nxt = S_IDLE;
                end
            end
        endcase
    end

    assign ahb.ahbso_hready = hready;
    assign ahb.ahbso_hresp  = hresp;
    assign ahb.ahbso_hrdata = hrdata_q;
    assign ahb.ahbso_hcache = 1'b1;

endmodule
